cfkbdencode: RTL and testbench
==============================

// Module: cfkbdencode
// PURPOSE
//  Keyboard-side encoder for the 1052/2150 console adapter; inverse of the printer function decoder.
//  Debounces keyboard contacts and tracks the shift (case) latch.
//  Encodes each keystroke into an EBCDIC data-register byte and presents it to the adapter
//  channel logic with a valid/taken handshake.
//  Also reports function bytes: space, NL, and carrier return.
// PARAMETERS
//  SETTLE_CYCLES  4  consecutive i_clk cycles the contact pattern must be stable before acceptance (>=1)
// PORTS
//  i_clk                   in   1  clock; single clock domain
//  i_reset                 in   1  synchronous, active-high reset
//  i_kbd_enable            in   1  adapter has unlocked the keyboard (proceed); 0 = ignore keys
//  i_key_down              in   1  a character key's permutation contacts are closed
//  i_key_code              in   6  permutation-bar code of the character key
//  i_space_key             in   1  space bar contact
//  i_return_key            in   1  carrier return key contact
//  i_shift_uc              in   1  shift-to-upper contact
//  i_shift_lc              in   1  shift-to-lower contact
//  i_data_taken            in   1  channel logic accepts o_data_reg; meaningful only while o_data_valid
//  o_data_reg              out  8  EBCDIC byte, bit 0 = MSB as in the data register
//  o_data_valid            out  1  o_data_reg holds an unaccepted byte
//  o_function              out  1  presented byte is a function byte (8'h40 or 8'h15)
//  o_carrier_return_latch  out  1  set with NL byte; cleared on its acceptance
//  o_case_latch            out  1  1 = upper case, 0 = lower case
//  o_bad_code              out  1  one-cycle pulse: undefined key code was mapped to 8'h6F
// BEHAVIOUR
//  Reset state: all outputs 0, o_data_reg=8'h00, case latch lower, FSM IDLE, settle counter 0.
//  Reset mid-operation: a pending byte is discarded without handshake.
//  FSM states IDLE -> SETTLE -> PRESENT -> RELEASE -> IDLE.
//  Contact vector: {i_return_key, i_space_key, i_shift_uc, i_shift_lc, i_key_down, i_key_code}.
//  IDLE: any contact active and i_kbd_enable=1 -> SETTLE; snapshot the vector; counter=1.
//   Contacts are ignored while i_kbd_enable=0.
//  SETTLE: vector equals snapshot -> counter++.
//   Vector differs -> re-snapshot, counter=1.
//   All contacts open -> IDLE; a bounce produces no byte.
//   counter==SETTLE_CYCLES -> act on the snapshot, using priority return > space > shift > character:
//   return: o_data_reg=8'h15; set o_function and o_carrier_return_latch; -> PRESENT
//   space: o_data_reg=8'h40; set o_function; -> PRESENT
//   shift_uc only: case latch=1. shift_lc only: case latch=0.
//    Both shift contacts together: no change. Any shift: no byte; -> RELEASE.
//   character: o_data_reg = kbd_to_ebcdic(code, case latch); o_function=0; -> PRESENT.
//    Undefined code: o_data_reg=8'h6F and o_bad_code pulses once.
//  PRESENT: o_data_valid=1; o_data_reg and o_function are held stable.
//   i_data_taken=1 -> on the next edge clear valid, o_function and cr latch; -> RELEASE.
//   i_kbd_enable falls before i_data_taken -> retract: valid, function and cr latch to 0; -> RELEASE.
//  RELEASE: wait until all contacts are open for SETTLE_CYCLES consecutive cycles, then -> IDLE.
//   No rollover: keys pressed during RELEASE produce nothing.
//  Latency: valid rises SETTLE_CYCLES+1 cycles after the first stable contact cycle.
//  Case latch changes only via shift keys; it persists across bytes and i_kbd_enable changes.
//  kbd_to_ebcdic (lc/uc):
//   1-9 -> 8'h81-89 / 8'hC1-C9
//   10-18 -> 8'h91-99 / 8'hD1-D9
//   19-26 -> 8'hA2-A9 / 8'hE2-E9
//   32-41 -> 8'hF0-F9 in both cases
//   every other code -> 8'h6F with o_bad_code
// STRUCTURE
//  Shared package cfkbd_pkg holds:
//   the FSM state enum;
//   constants EBCDIC_SPACE=8'h40, EBCDIC_NL=8'h15, EBCDIC_QMARK=8'h6F;
//   function kbd_to_ebcdic.
//   The printer function decoder also uses EBCDIC_SPACE and EBCDIC_NL from this package.
//  Sub-module cfkbd_debounce: snapshot register plus settle counter, with stable/open outputs.
//  The FSM and output registers stay in cfkbdencode.
// TESTING
//  1. Reset; enable=1; code=1 held 4 cycles -> valid, o_data_reg=8'h81, function=0.
//     Taken -> valid=0.
//  2. shift_uc held 4 cycles, released; then code=19 -> 8'hE2 with o_case_latch=1.
//     The shift press alone produces no valid pulse.
//  3. return+space+code=5 together -> 8'h15, function=1, cr latch=1.
//     Taken -> cr latch=0 on the next cycle.
//  4. Contacts toggling every 2 cycles, then opened -> no valid ever.
//     Code held with enable=0 -> no valid.
//  5. Code=50 -> 8'h6F with a single o_bad_code pulse.
//     Second key pressed during RELEASE -> ignored.
//  6. Byte pending, then enable drops -> valid falls and no byte is taken.
//     Reset asserted in PRESENT -> all outputs 0 and FSM IDLE next cycle.

Source files
------------

// File: rtl/cfkbd_pkg.sv
// Shared definitions for the 1052/2150 console keyboard encoder and printer decoder.
package cfkbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_PRESENT,
    ST_RELEASE
  } state_e;

  typedef enum logic [1:0] {
    DB_HOLD,
    DB_LOAD,
    DB_INC,
    DB_CLR
  } db_cmd_e;

  // Contact vector: {return, space, shift_uc, shift_lc, key_down, key_code[5:0]}
  localparam int CONTACT_W = 11;

  localparam logic [7:0] EBCDIC_SPACE = 8'h40;
  localparam logic [7:0] EBCDIC_NL    = 8'h15;
  localparam logic [7:0] EBCDIC_QMARK = 8'h6F;

  // EBCDIC_QMARK lies outside every defined range, so it doubles as the undefined-code marker.
  function automatic logic [7:0] kbd_to_ebcdic(input logic [5:0] code, input logic upper);
    logic [7:0] c;
    logic [7:0] res;
    c = {2'b00, code};
    if (code >= 6'd1 && code <= 6'd9)
      res = (upper ? 8'hC1 : 8'h81) + (c - 8'd1);
    else if (code >= 6'd10 && code <= 6'd18)
      res = (upper ? 8'hD1 : 8'h91) + (c - 8'd10);
    else if (code >= 6'd19 && code <= 6'd26)
      res = (upper ? 8'hE2 : 8'hA2) + (c - 8'd19);
    else if (code >= 6'd32 && code <= 6'd41)
      res = 8'hF0 + (c - 8'd32);
    else
      res = EBCDIC_QMARK;
    return res;
  endfunction

endpackage

// File: rtl/cfkbd_debounce.sv
// Contact snapshot register and settle counter; the FSM chooses when to load, count or clear.
module cfkbd_debounce
  import cfkbd_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [CONTACT_W-1:0] i_vec,
  input  db_cmd_e              i_cmd,
  output logic [CONTACT_W-1:0] o_snap,
  output logic                 o_same,
  output logic                 o_open,
  output logic                 o_settled
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES);

  logic [CONTACT_W-1:0] snap_q, snap_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  always_comb begin
    snap_d = snap_q;
    cnt_d  = cnt_q;
    unique case (i_cmd)
      DB_LOAD: begin
        snap_d = i_vec;
        cnt_d  = CNT_W'(1);
      end
      DB_INC:  if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      DB_CLR:  cnt_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      snap_q <= '0;
      cnt_q  <= '0;
    end else begin
      snap_q <= snap_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_snap    = snap_q;
  assign o_same    = (i_vec == snap_q);
  assign o_open    = ~|i_vec[CONTACT_W-1:6];
  assign o_settled = (cnt_q == CNT_MAX);

endmodule

// File: rtl/cfkbdencode.sv
// Keyboard encoder: debounces contacts, tracks case, presents EBCDIC bytes with valid/taken.
module cfkbdencode
  import cfkbd_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_kbd_enable,
  input  logic       i_key_down,
  input  logic [5:0] i_key_code,
  input  logic       i_space_key,
  input  logic       i_return_key,
  input  logic       i_shift_uc,
  input  logic       i_shift_lc,
  input  logic       i_data_taken,
  output logic [7:0] o_data_reg,
  output logic       o_data_valid,
  output logic       o_function,
  output logic       o_carrier_return_latch,
  output logic       o_case_latch,
  output logic       o_bad_code
);

  logic [CONTACT_W-1:0] vec, snap;
  logic                 db_same, db_open, db_settled;
  db_cmd_e              db_cmd;

  state_e     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       func_q, func_d;
  logic       cr_q, cr_d;
  logic       case_q, case_d;
  logic       bad_q, bad_d;
  logic [7:0] char_byte;

  assign vec = {i_return_key, i_space_key, i_shift_uc, i_shift_lc, i_key_down, i_key_code};

  cfkbd_debounce #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_debounce (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_vec     (vec),
    .i_cmd     (db_cmd),
    .o_snap    (snap),
    .o_same    (db_same),
    .o_open    (db_open),
    .o_settled (db_settled)
  );

  assign char_byte = kbd_to_ebcdic(snap[5:0], case_q);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    func_d  = func_q;
    cr_d    = cr_q;
    case_d  = case_q;
    bad_d   = 1'b0;
    db_cmd  = DB_HOLD;
    unique case (state_q)
      ST_IDLE: begin
        if (i_kbd_enable && !db_open) begin
          db_cmd  = DB_LOAD;
          state_d = ST_SETTLE;
        end else begin
          db_cmd = DB_CLR;
        end
      end
      ST_SETTLE: begin
        if (db_settled) begin
          db_cmd = DB_CLR;
          if (snap[10]) begin
            data_d  = EBCDIC_NL;
            func_d  = 1'b1;
            cr_d    = 1'b1;
            valid_d = 1'b1;
            state_d = ST_PRESENT;
          end else if (snap[9]) begin
            data_d  = EBCDIC_SPACE;
            func_d  = 1'b1;
            valid_d = 1'b1;
            state_d = ST_PRESENT;
          end else if (snap[8] || snap[7]) begin
            if (snap[8] && !snap[7]) case_d = 1'b1;
            else if (snap[7] && !snap[8]) case_d = 1'b0;
            state_d = ST_RELEASE;
          end else if (snap[6]) begin
            data_d  = char_byte;
            func_d  = 1'b0;
            bad_d   = (char_byte == EBCDIC_QMARK);
            valid_d = 1'b1;
            state_d = ST_PRESENT;
          end else begin
            state_d = ST_RELEASE;
          end
        end else if (db_open) begin
          db_cmd  = DB_CLR;
          state_d = ST_IDLE;
        end else if (!db_same) begin
          db_cmd = DB_LOAD;
        end else begin
          db_cmd = DB_INC;
        end
      end
      ST_PRESENT: begin
        db_cmd = DB_CLR;
        // Taken wins over a simultaneous enable drop: the channel already has the byte.
        if (i_data_taken || !i_kbd_enable) begin
          valid_d = 1'b0;
          func_d  = 1'b0;
          cr_d    = 1'b0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (db_settled) begin
          db_cmd  = DB_CLR;
          state_d = ST_IDLE;
        end else if (db_open) begin
          db_cmd = DB_INC;
        end else begin
          db_cmd = DB_CLR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      func_q  <= 1'b0;
      cr_q    <= 1'b0;
      case_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      func_q  <= func_d;
      cr_q    <= cr_d;
      case_q  <= case_d;
      bad_q   <= bad_d;
    end
  end

  assign o_data_reg             = data_q;
  assign o_data_valid           = valid_q;
  assign o_function             = func_q;
  assign o_carrier_return_latch = cr_q;
  assign o_case_latch           = case_q;
  assign o_bad_code             = bad_q;

endmodule

// File: tb/tb_cfkbdencode.sv
// Directed scoreboard bench for the keyboard encoder.
module tb_cfkbdencode;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       kbd_enable = 1'b0;
  logic       key_down = 1'b0;
  logic [5:0] key_code = 6'd0;
  logic       space_key = 1'b0;
  logic       return_key = 1'b0;
  logic       shift_uc = 1'b0;
  logic       shift_lc = 1'b0;
  logic       data_taken = 1'b0;
  logic [7:0] data_reg;
  logic       data_valid;
  logic       func;
  logic       cr_latch;
  logic       case_latch;
  logic       bad_code;

  int checks = 0;
  int errors = 0;
  int vld_rises = 0;
  int bad_pulses = 0;
  logic vld_prev = 1'b0;
  logic [8:0] sb[$];

  always #5 clk = ~clk;

  cfkbdencode #(.SETTLE_CYCLES(4)) dut (
    .i_clk                  (clk),
    .i_reset                (rst),
    .i_kbd_enable           (kbd_enable),
    .i_key_down             (key_down),
    .i_key_code             (key_code),
    .i_space_key            (space_key),
    .i_return_key           (return_key),
    .i_shift_uc             (shift_uc),
    .i_shift_lc             (shift_lc),
    .i_data_taken           (data_taken),
    .o_data_reg             (data_reg),
    .o_data_valid           (data_valid),
    .o_function             (func),
    .o_carrier_return_latch (cr_latch),
    .o_case_latch           (case_latch),
    .o_bad_code             (bad_code)
  );

  always @(negedge clk) begin
    vld_prev <= data_valid;
    if (data_valid && !vld_prev) vld_rises <= vld_rises + 1;
    if (bad_code) bad_pulses <= bad_pulses + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // v = {return, space, uc, lc, key_down, code}
  task automatic press(input logic [10:0] v, input int n);
    {return_key, space_key, shift_uc, shift_lc, key_down, key_code} = v;
    step(n);
    {return_key, space_key, shift_uc, shift_lc, key_down, key_code} = 11'd0;
  endtask

  function automatic logic [10:0] chr(input int c);
    return {5'b00001, 6'(c)};
  endfunction

  task automatic expect_byte(input string tag, input int exp_wait);
    int waited;
    logic [8:0] e;
    waited = 0;
    while (!data_valid && waited < 20) begin
      step(1);
      waited++;
    end
    chk({tag, "_valid"}, 32'(data_valid), 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_byte"}, 32'({func, data_reg}), 32'(e));
    end
    if (exp_wait >= 0) chk({tag, "_latency"}, 32'(waited), 32'(exp_wait));
  endtask

  task automatic take();
    data_taken = 1'b1;
    step(1);
    data_taken = 1'b0;
  endtask

  initial begin
    int r0;
    int b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_data", 32'(data_reg), 32'h00);
    chk("rst_func", 32'(func), 32'd0);
    chk("rst_cr", 32'(cr_latch), 32'd0);
    chk("rst_case", 32'(case_latch), 32'd0);
    chk("rst_bad", 32'(bad_code), 32'd0);

    // Test 1: lowercase character
    kbd_enable = 1'b1;
    step(1);
    sb.push_back({1'b0, 8'h81});
    press(chr(1), 4);
    expect_byte("t1", 1);
    chk("t1_cr", 32'(cr_latch), 32'd0);
    take();
    chk("t1_taken_valid", 32'(data_valid), 32'd0);
    step(8);

    // Test 2: shift to upper, then character
    r0 = vld_rises;
    press({5'b00100, 6'd0}, 4);
    step(10);
    chk("t2_shift_no_byte", 32'(vld_rises), 32'(r0));
    chk("t2_case_up", 32'(case_latch), 32'd1);
    sb.push_back({1'b0, 8'hE2});
    press(chr(19), 4);
    expect_byte("t2", 1);
    chk("t2_case_hold", 32'(case_latch), 32'd1);
    take();
    step(8);

    // Test 3: return beats space and character
    sb.push_back({1'b1, 8'h15});
    press({5'b11001, 6'd5}, 4);
    expect_byte("t3", 1);
    chk("t3_cr_set", 32'(cr_latch), 32'd1);
    take();
    chk("t3_cr_clear", 32'(cr_latch), 32'd0);
    chk("t3_valid_clear", 32'(data_valid), 32'd0);
    chk("t3_func_clear", 32'(func), 32'd0);
    step(8);

    // Test 4: bounce, then keys while disabled
    r0 = vld_rises;
    for (int i = 0; i < 5; i++) begin
      press(chr(3), 2);
      step(2);
    end
    step(10);
    chk("t4_bounce", 32'(vld_rises), 32'(r0));
    kbd_enable = 1'b0;
    press(chr(3), 12);
    step(4);
    chk("t4_disabled", 32'(vld_rises), 32'(r0));
    kbd_enable = 1'b1;
    step(8);
    chk("t4_sb_idle", 32'(sb.size()), 32'd0);

    // Test 5: undefined code, then rollover attempt during release
    b0 = bad_pulses;
    sb.push_back({1'b0, 8'h6F});
    press(chr(50), 4);
    expect_byte("t5", 1);
    take();
    chk("t5_bad_once", 32'(bad_pulses), 32'(b0 + 1));
    r0 = vld_rises;
    press(chr(2), 10);
    step(12);
    chk("t5_rollover", 32'(vld_rises), 32'(r0));
    chk("t5_bad_still_once", 32'(bad_pulses), 32'(b0 + 1));

    // Test 6a: retract on enable drop (case still upper)
    sb.push_back({1'b0, 8'hC4});
    press(chr(4), 4);
    expect_byte("t6a", 1);
    kbd_enable = 1'b0;
    step(1);
    chk("t6a_retract_valid", 32'(data_valid), 32'd0);
    chk("t6a_retract_func", 32'(func), 32'd0);
    kbd_enable = 1'b1;
    step(10);
    chk("t6a_no_reoffer", 32'(data_valid), 32'd0);

    // Test 6b: reset while presenting
    sb.push_back({1'b0, 8'hC6});
    press(chr(6), 4);
    expect_byte("t6b", 1);
    rst = 1'b1;
    step(1);
    chk("t6b_valid", 32'(data_valid), 32'd0);
    chk("t6b_data", 32'(data_reg), 32'h00);
    chk("t6b_func", 32'(func), 32'd0);
    chk("t6b_cr", 32'(cr_latch), 32'd0);
    chk("t6b_case", 32'(case_latch), 32'd0);
    chk("t6b_bad", 32'(bad_code), 32'd0);
    rst = 1'b0;
    sb.push_back({1'b0, 8'h87});
    press(chr(7), 4);
    expect_byte("t6b_after", 1);
    take();
    step(8);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
